seq_gen: RTL and testbench



---
 rtl/seq_gen_if.sv | 34 +++
 rtl/seq_gen.sv | 109 ++++++++++
 tb/tb_seq_gen.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_gen_if.sv
// Handshake/bus bundle for seq_gen; `loop` exists only when SEQ_GEN_LOOP_EN is defined.
interface seq_gen_if #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 5
);
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic             stop;
`ifdef SEQ_GEN_LOOP_EN
    logic             loop;
`endif
    logic             out;
    logic             out_valid;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] bit_idx;

    modport master (
        output start, pattern, len, stop,
`ifdef SEQ_GEN_LOOP_EN
        output loop,
`endif
        input  out, out_valid, busy, done, bit_idx
    );

    modport slave (
        input  start, pattern, len, stop,
`ifdef SEQ_GEN_LOOP_EN
        input  loop,
`endif
        output out, out_valid, busy, done, bit_idx
    );
endinterface

// File: rtl/seq_gen.sv
// Serial pattern generator: shifts a captured word out LSB-first with a valid qualifier.
// Optional continuous repeat of the frame is enabled with the SEQ_GEN_LOOP_EN macro.
module seq_gen #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 5
) (
    input  logic      clk,
    input  logic      rst,
    seq_gen_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] shadow;
    logic [LEN_W-1:0] last_idx;
    logic [LEN_W-1:0] bit_idx_q;
    logic             out_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             done_q;

    logic [LEN_W-1:0] len_eff;
    logic [LEN_W-1:0] last_in;
    logic [LEN_W-1:0] nxt_idx;
    logic [WIDTH-1:0] shifted;
    logic             nxt_bit;
    logic             loop_en;

`ifdef SEQ_GEN_LOOP_EN
    assign loop_en = bus.loop;
`else
    assign loop_en = 1'b0;
`endif

    // Zero or oversized lengths mean a full-width frame, so bit_idx stays below WIDTH.
    always_comb begin
        len_eff = bus.len;
        if (bus.len == '0 || bus.len > LEN_W'(WIDTH))
            len_eff = LEN_W'(WIDTH);
        last_in = len_eff - 1'b1;
        nxt_idx = bit_idx_q + 1'b1;
        shifted = shadow >> nxt_idx;
        nxt_bit = shifted[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shadow      <= '0;
            last_idx    <= '0;
            bit_idx_q   <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state)
                SHIFT: begin
                    if (bus.stop) begin
                        state       <= IDLE;
                        bit_idx_q   <= '0;
                        out_q       <= 1'b0;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end else if (bit_idx_q == last_idx) begin
                        if (loop_en) begin
                            bit_idx_q <= '0;
                            out_q     <= shadow[0];
                        end else begin
                            state       <= DONE;
                            bit_idx_q   <= '0;
                            out_q       <= 1'b0;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end
                    end else begin
                        bit_idx_q <= nxt_idx;
                        out_q     <= nxt_bit;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new frame; DONE otherwise falls back to IDLE.
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state       <= SHIFT;
                        shadow      <= bus.pattern;
                        last_idx    <= last_in;
                        bit_idx_q   <= '0;
                        out_q       <= bus.pattern[0];
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end else begin
                        state       <= IDLE;
                        out_q       <= 1'b0;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.bit_idx   = bit_idx_q;
endmodule

// File: tb/tb_seq_gen.sv
// Self-checking bench for seq_gen: queue-based frame model checked every cycle plus directed literals.
module tb_seq_gen;
    localparam int WIDTH = 16;
    localparam int LEN_W = 5;

    logic clk;
    logic rst;

    seq_gen_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

    seq_gen #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: a queue of (index, bit) entries still to be shown on the wire.
    int   mq[$];
    int   m_frame[$];
    logic m_valid = 1'b0;
    logic m_done  = 1'b0;
    logic m_bit   = 1'b0;
    int   m_idx   = 0;

    function automatic void build_frame(input logic [WIDTH-1:0] pat, input logic [LEN_W-1:0] ln);
        int l;
        l = (ln == 0 || ln > WIDTH) ? WIDTH : int'(ln);
        m_frame.delete();
        for (int i = 0; i < l; i++) m_frame.push_back(i * 2 + int'(pat[i]));
        mq = m_frame;
    endfunction

    function automatic void pop_bit();
        int e;
        e = mq.pop_front();
        m_bit = e[0];
        m_idx = e >> 1;
    endfunction

    logic loop_in;
`ifdef SEQ_GEN_LOOP_EN
    assign loop_in = bus.loop;
`else
    assign loop_in = 1'b0;
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_valid = 1'b0;
            m_done  = 1'b0;
        end else if (m_valid) begin
            if (bus.stop) begin
                mq.delete();
                m_valid = 1'b0;
                m_done  = 1'b0;
            end else if (mq.size() > 0) begin
                pop_bit();
            end else if (loop_in) begin
                mq = m_frame;
                pop_bit();
            end else begin
                m_valid = 1'b0;
                m_done  = 1'b1;
            end
        end else if (bus.start) begin
            build_frame(bus.pattern, bus.len);
            pop_bit();
            m_valid = 1'b1;
            m_done  = 1'b0;
        end else begin
            m_done = 1'b0;
        end
    end

    // Per-cycle comparison plus capture of the serial stream for literal checks.
    logic [31:0] cap_bits;
    int          cap_n;
    int          done_n;

    always @(negedge clk) begin
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("busy", 32'(bus.busy), 32'(m_valid));
        chk("done", 32'(bus.done), 32'(m_done));
        if (m_valid) begin
            chk("out", 32'(bus.out), 32'(m_bit));
            chk("bit_idx", 32'(bus.bit_idx), 32'(m_idx));
        end else begin
            chk("out_idle", 32'(bus.out), 32'd0);
        end
        if (bus.out_valid === 1'b1 && cap_n < 32) begin
            cap_bits[cap_n] = bus.out;
            cap_n++;
        end
        if (bus.done === 1'b1) done_n++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_cap();
        cap_bits = '0;
        cap_n    = 0;
        done_n   = 0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(bus.done), 32'd1);
    endtask

    task automatic send(input logic [WIDTH-1:0] pat, input logic [LEN_W-1:0] ln);
        clr_cap();
        bus.pattern = pat;
        bus.len     = ln;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
    endtask

    initial begin
        int n;
        clr_cap();
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.pattern = '0;
        bus.len     = '0;
`ifdef SEQ_GEN_LOOP_EN
        bus.loop    = 1'b0;
`endif
        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_bit_idx", 32'(bus.bit_idx), 32'd0);
        rst = 1'b0;
        tick();

        // Full-width frame with the reference pattern
        send(16'b0110010111011110, 5'd0);
        chk("first_valid", 32'(bus.out_valid), 32'd1);
        chk("first_bit", 32'(bus.out), 32'd0);
        chk("first_idx", 32'(bus.bit_idx), 32'd0);
        wait_done(40);
        chk("full_busy_at_done", 32'(bus.busy), 32'd0);
        tick(); tick();
        chk("full_len", 32'(cap_n), 32'd16);
        chk("full_bits", cap_bits, 32'h0000_65DE);
        chk("full_done_pulses", 32'(done_n), 32'd1);

        // Short frame
        send(16'h0005, 5'd3);
        wait_done(20);
        tick(); tick();
        chk("short_len", 32'(cap_n), 32'd3);
        chk("short_bits", cap_bits, 32'h5);

        // Oversized length clamps to WIDTH
        send(16'hA5C3, 5'd20);
        wait_done(40);
        tick(); tick();
        chk("clamp_len", 32'(cap_n), 32'd16);
        chk("clamp_bits", cap_bits, 32'h0000_A5C3);

        // Abort at bit 6
        send(16'hFFFF, 5'd0);
        n = 0;
        while (bus.bit_idx !== 5'd6 && n < 20) begin
            tick();
            n++;
        end
        chk("abort_reach_idx6", 32'(bus.bit_idx), 32'd6);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("abort_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        repeat (4) tick();
        chk("abort_no_done", 32'(done_n), 32'd0);
        chk("abort_len", 32'(cap_n), 32'd7);
        send(16'h0002, 5'd2);
        wait_done(20);
        tick(); tick();
        chk("post_abort_bits", cap_bits, 32'h2);

        // start during SHIFT with a different pattern is ignored
        send(16'h000A, 5'd4);
        bus.pattern = 16'h0005;
        bus.len     = 5'd9;
        bus.start   = 1'b1;
        tick(); tick();
        bus.start   = 1'b0;
        wait_done(20);
        tick(); tick();
        chk("ignore_len", 32'(cap_n), 32'd4);
        chk("ignore_bits", cap_bits, 32'hA);

        // start held through DONE: next frame one cycle after done
        clr_cap();
        bus.pattern = 16'h0003;
        bus.len     = 5'd2;
        bus.start   = 1'b1;
        wait_done(20);
        tick();
        chk("b2b_valid", 32'(bus.out_valid), 32'd1);
        chk("b2b_idx", 32'(bus.bit_idx), 32'd0);
        bus.start = 1'b0;
        wait_done(20);
        tick(); tick();
        chk("b2b_total", 32'(cap_n), 32'd4);

        // Asynchronous reset in the middle of a frame
        send(16'h00F0, 5'd8);
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        chk("arst_idx", 32'(bus.bit_idx), 32'd0);
        chk("arst_out", 32'(bus.out), 32'd0);
        #3 rst = 1'b0;
        tick();

`ifdef SEQ_GEN_LOOP_EN
        // Continuous repeat, dropped during the second pass
        bus.loop = 1'b1;
        send(16'h0009, 5'd4);
        repeat (5) tick();
        bus.loop = 1'b0;
        wait_done(20);
        tick(); tick();
        chk("loop_len", 32'(cap_n), 32'd8);
        chk("loop_bits", cap_bits, 32'h99);
        chk("loop_done_pulses", 32'(done_n), 32'd1);
`endif

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
